game_flow_ctrl: RTL and testbench

Top-level game sequencer that sits directly upstream of the dino game core. It converts raw start/pause keys into a game state machine and drives the core's `run_game` enable and restart strobe. It also consumes the core's `collision_detected` and `game_cleared` flags, and produces a countdown digit, a 4-digit BCD score and a stage number (1..3) that selects which game core variant is active.

---
 rtl/game_flow_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: start/pause sequencer in front of the dino game core.
// Turns key presses into run/restart control, a countdown, a BCD score and a stage select.
module game_flow_ctrl #(
    parameter int unsigned TICK_PERIOD  = 1000,
    parameter int unsigned SCORE_PERIOD = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_pause,
    input  logic        collision_detected,
    input  logic        game_cleared,
    output logic        run_game,
    output logic        restart,
    output logic [2:0]  state,
    output logic [1:0]  countdown,
    output logic [15:0] score_bcd,
    output logic [1:0]  stage
);
    localparam int unsigned TICK_W  = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned SCORE_W = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               key_start_q, key_pause_q;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SCORE_W-1:0] presc_q, presc_d;
    logic [1:0]         countdown_q, countdown_d;
    logic [15:0]        score_q, score_d;
    logic [1:0]         stage_q, stage_d;
    logic               restart_q, restart_d;

    logic press_start, press_pause;
    logic tick_done, count_done, count_entry;

    assign press_start = key_start & ~key_start_q;
    assign press_pause = key_pause & ~key_pause_q;
    assign tick_done   = (state_q == S_COUNT) && (tick_q == TICK_W'(TICK_PERIOD - 1));
    assign count_done  = tick_done && (countdown_q == 2'd1);
    assign count_entry = (state_d == S_COUNT) && (state_q != S_COUNT);

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (press_start) state_d = S_COUNT;
            S_COUNT: if (count_done) state_d = S_RUN;
            S_RUN: begin
                if (collision_detected)  state_d = S_OVER;
                else if (game_cleared)   state_d = S_CLEAR;
                else if (press_pause)    state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (press_start)         state_d = S_IDLE;
                else if (press_pause)    state_d = S_RUN;
            end
            S_OVER, S_CLEAR: if (press_start) state_d = S_COUNT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run_game = (state_q == S_RUN);
    end

    // Countdown, score prescaler, score and stage bookkeeping.
    always_comb begin
        tick_d      = tick_q;
        presc_d     = presc_q;
        countdown_d = countdown_q;
        score_d     = score_q;
        stage_d     = stage_q;
        restart_d   = count_entry;

        if (state_q == S_COUNT) begin
            if (tick_done) begin
                tick_d      = '0;
                countdown_d = countdown_q - 2'd1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        if (state_q == S_RUN) begin
            if (presc_q == SCORE_W'(SCORE_PERIOD - 1)) begin
                presc_d = '0;
                score_d = bcd_inc(score_q);
            end else begin
                presc_d = presc_q + SCORE_W'(1);
            end
        end

        if ((state_q == S_IDLE) || ((state_q == S_OVER) && press_start)) begin
            score_d = '0;
        end

        if ((state_q == S_CLEAR) && press_start) begin
            stage_d = (stage_q == 2'd3) ? 2'd1 : stage_q + 2'd1;
        end

        // Fresh countdown and score phase on every COUNT entry.
        if (count_entry) begin
            tick_d      = '0;
            presc_d     = '0;
            countdown_d = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_start_q <= 1'b1;
            key_pause_q <= 1'b1;
            tick_q      <= '0;
            presc_q     <= '0;
            countdown_q <= 2'd0;
            score_q     <= 16'h0000;
            stage_q     <= 2'd1;
            restart_q   <= 1'b0;
        end else begin
            key_start_q <= key_start;
            key_pause_q <= key_pause;
            tick_q      <= tick_d;
            presc_q     <= presc_d;
            countdown_q <= countdown_d;
            score_q     <= score_d;
            stage_q     <= stage_d;
            restart_q   <= restart_d;
        end
    end

    assign restart   = restart_q;
    assign state     = state_q;
    assign countdown = countdown_q;
    assign score_bcd = score_q;
    assign stage     = stage_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus random key/flag traffic,
// checked every cycle against a behavioural model of the game flow.
module tb_game_flow_ctrl;
    localparam int unsigned TP = 4;
    localparam int unsigned SP = 3;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;
    localparam int M_CLEAR = 5;

    logic        clk = 1'b0;
    logic        rst, key_start, key_pause, collision_detected, game_cleared;
    logic        run_game, restart;
    logic [2:0]  state;
    logic [1:0]  countdown;
    logic [15:0] score_bcd;
    logic [1:0]  stage;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    // Model: game phase, cycles left in countdown, RUN cycles since last point.
    int m_state, m_cnt_left, m_run_cyc, m_score, m_stage;
    bit m_restart, m_prev_start, m_prev_pause, m_ps, m_pp;

    always #5 clk = ~clk;

    game_flow_ctrl #(.TICK_PERIOD(TP), .SCORE_PERIOD(SP)) dut (
        .clk                (clk),
        .rst                (rst),
        .key_start          (key_start),
        .key_pause          (key_pause),
        .collision_detected (collision_detected),
        .game_cleared       (game_cleared),
        .run_game           (run_game),
        .restart            (restart),
        .state              (state),
        .countdown          (countdown),
        .score_bcd          (score_bcd),
        .stage              (stage)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
            if (failures >= 50) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic enter_count();
        m_state    = M_COUNT;
        m_cnt_left = 3 * TP;
        m_run_cyc  = 0;
        m_restart  = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_state = M_IDLE; m_cnt_left = 0; m_run_cyc = 0; m_score = 0; m_stage = 1;
            m_restart = 1'b0; m_prev_start = 1'b1; m_prev_pause = 1'b1;
        end else begin
            m_ps = key_start && !m_prev_start;
            m_pp = key_pause && !m_prev_pause;
            m_prev_start = key_start;
            m_prev_pause = key_pause;
            m_restart = 1'b0;
            case (m_state)
                M_IDLE: begin
                    m_score = 0;
                    if (m_ps) enter_count();
                end
                M_COUNT: begin
                    m_cnt_left--;
                    if (m_cnt_left == 0) m_state = M_RUN;
                end
                M_RUN: begin
                    m_run_cyc++;
                    if (m_run_cyc == SP) begin
                        m_run_cyc = 0;
                        if (m_score < 9999) m_score++;
                    end
                    if (collision_detected) m_state = M_OVER;
                    else if (game_cleared)  m_state = M_CLEAR;
                    else if (m_pp)          m_state = M_PAUSE;
                end
                M_PAUSE: begin
                    if (m_ps)      m_state = M_IDLE;
                    else if (m_pp) m_state = M_RUN;
                end
                M_OVER: if (m_ps) begin m_score = 0; enter_count(); end
                M_CLEAR: if (m_ps) begin m_stage = (m_stage % 3) + 1; enter_count(); end
                default: m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("run_game", 32'(run_game), 32'(m_state == M_RUN));
            chk("restart", 32'(restart), 32'(m_restart));
            chk("countdown", 32'(countdown),
                (m_state == M_COUNT) ? 32'((m_cnt_left + TP - 1) / TP) : 32'd0);
            chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
            chk("stage", 32'(stage), 32'(m_stage));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start_key();
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
    endtask

    task automatic clear_and_restart();
        game_cleared = 1'b1;
        @(negedge clk);
        game_cleared = 1'b0;
        press_start_key();
        cycles(12);
    endtask

    initial begin : stim
        int cd_seq[12];
        int exp_cd[12];
        int rpulses;
        exp_cd = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1};
        rst = 1'b1; key_start = 1'b0; key_pause = 1'b0;
        collision_detected = 1'b0; game_cleared = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_stage", 32'(stage), 32'd1);
        cycles(2);
        rst = 1'b0;
        cycles(7);

        // Start: restart pulse, countdown 3/2/1, RUN after 12 cycles.
        press_start_key();
        chk("restart_first", 32'(restart), 32'd1);
        cd_seq[0] = int'(countdown);
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            cd_seq[k] = int'(countdown);
            if (k == 1) chk("restart_second", 32'(restart), 32'd0);
        end
        for (int k = 0; k < 12; k++) chk("countdown_seq", 32'(cd_seq[k]), 32'(exp_cd[k]));
        chk("run_before", 32'(run_game), 32'd0);
        @(negedge clk);
        chk("run_rise", 32'(run_game), 32'd1);

        // 30 RUN, 10 PAUSE, 3 RUN cycles.
        cycles(29);
        key_pause = 1'b1;
        @(negedge clk);
        key_pause = 1'b0;
        chk("pause_state", 32'(state), 32'd3);
        chk("pause_score_in", 32'(score_bcd), 32'h0010);
        cycles(9);
        key_pause = 1'b1;
        @(negedge clk);
        key_pause = 1'b0;
        chk("pause_score_out", 32'(score_bcd), 32'h0010);
        cycles(3);
        chk("resume_score", 32'(score_bcd), 32'h0011);

        // Collision beats cleared and pause.
        collision_detected = 1'b1; game_cleared = 1'b1; key_pause = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0; game_cleared = 1'b0; key_pause = 1'b0;
        chk("over_state", 32'(state), 32'd4);
        chk("over_run", 32'(run_game), 32'd0);
        press_start_key();
        chk("over_restart_state", 32'(state), 32'd1);
        chk("over_stage", 32'(stage), 32'd1);
        chk("over_score", 32'(score_bcd), 32'h0000);
        cycles(12);

        // Reach stage 3, earn 42 points, then clear back to stage 1.
        clear_and_restart();
        clear_and_restart();
        chk("stage3", 32'(stage), 32'd3);
        cycles(125);
        game_cleared = 1'b1;
        @(negedge clk);
        game_cleared = 1'b0;
        chk("clear_state", 32'(state), 32'd5);
        chk("clear_score", 32'(score_bcd), 32'h0042);
        press_start_key();
        chk("wrap_stage", 32'(stage), 32'd1);
        chk("wrap_score", 32'(score_bcd), 32'h0042);
        rpulses = int'(restart);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            rpulses += int'(restart);
        end
        chk("wrap_restart_pulses", 32'(rpulses), 32'd1);
        @(negedge clk);

        // Long run to the saturation point.
        cycles(29868);
        chk("score_9998", 32'(score_bcd), 32'h9998);
        cycles(3);
        chk("score_9999", 32'(score_bcd), 32'h9999);
        cycles(6);
        chk("score_hold", 32'(score_bcd), 32'h9999);

        // Reset mid-COUNT with start held through reset release.
        game_cleared = 1'b1;
        @(negedge clk);
        game_cleared = 1'b0;
        key_start = 1'b1;
        @(negedge clk);
        chk("stage2", 32'(stage), 32'd2);
        cycles(5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_countdown", 32'(countdown), 32'd0);
        chk("rst_stage", 32'(stage), 32'd1);
        chk("rst_restart", 32'(restart), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(3);
        chk("held_key_idle", 32'(state), 32'd0);
        key_start = 1'b0;
        @(negedge clk);

        // Random key and flag traffic.
        for (int i = 0; i < 3000; i++) begin
            key_start          = ($urandom_range(0, 7) == 0);
            key_pause          = ($urandom_range(0, 7) == 0);
            collision_detected = ($urandom_range(0, 60) == 0);
            game_cleared       = ($urandom_range(0, 60) == 0);
            rst                = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
